sprite_commit_scheduler: RTL and testbench
==========================================

SPRITE_COMMIT_SCHEDULER -- requirements
Module: sprite_commit_scheduler

Interface
REQ-001 The block SHALL have parameter VISIBLE_LINES, default 600, the first vga_vaddr value that is vertical blanking.
REQ-002 The block SHALL have parameter ENTRIES, default 32, the number of sprite-table entries; index width is 5 bits.
REQ-003 The block SHALL have one clock and asynchronous active-low reset: clk input 1, rising-edge clock; rstn input 1, asynchronous active-low reset.
REQ-004 cpu_we  input  1  CPU write strobe to the shadow table.
REQ-005 cpu_addr  input  5  shadow entry index.
REQ-006 cpu_din  input  26  entry: [25:22] image id (0 = empty), [21:11] x, [10:0] y.
REQ-007 commit_req  input  1  single-cycle request to publish the shadow table.
REQ-008 vga_vaddr  input  11  current VGA line.
REQ-009 rd_we  output  1  renderer table write strobe.
REQ-010 rd_addr  output  32  renderer entry index; bits [31:5] are always 0.
REQ-011 rd_din  output  32  renderer entry data; bits [31:26] are always 0.
REQ-012 busy  output  1  high while a commit is pending or in progress.
REQ-013 commit_done  output  1  one-cycle pulse when a commit completes.
REQ-014 commit_count  output  8  number of completed commits, wrapping 255 -> 0.

Function
REQ-015 The block SHALL hold a 32x26 shadow table and a 32-bit dirty vector.
REQ-016 On cpu_we, the block SHALL write cpu_din to shadow[cpu_addr] at the clock edge and set dirty[cpu_addr]; this is accepted in every state.
REQ-017 vblank SHALL be defined as (vga_vaddr >= VISIBLE_LINES), sampled combinationally each cycle.
REQ-018 The FSM SHALL have the states IDLE, WAIT_VB, COPY and DONE.
REQ-019 IDLE: on commit_req, the FSM SHALL go to WAIT_VB with idx = 0; otherwise it stays in IDLE.
REQ-020 WAIT_VB: the FSM SHALL go to COPY in the cycle after vblank is sampled high; idx is retained.
REQ-021 COPY: in each cycle, if dirty[idx] = 1, the block SHALL assert rd_we = 1, rd_addr = idx and rd_din = shadow[idx], and clear dirty[idx].
REQ-022 COPY: in each cycle, if dirty[idx] = 0, the block SHALL hold rd_we = 0.
REQ-023 COPY: idx SHALL increment by one each cycle, giving exactly one index per cycle and a fixed scan of 32 cycles.
REQ-024 COPY with idx = 31 processed SHALL transition to DONE.
REQ-025 If vblank deasserts in COPY, the block SHALL complete the current index, return to WAIT_VB with the next idx, and resume at the next vblank; no entry is skipped or duplicated.
REQ-026 DONE SHALL last one cycle: commit_done = 1, commit_count += 1, then go to WAIT_VB with idx = 0 if pend = 1 (clearing pend), otherwise to IDLE.
REQ-027 commit_req in WAIT_VB, COPY or DONE SHALL set the pend flag; multiple requests collapse into one.
REQ-028 If cpu_we targets the current idx in the same cycle as the copy, the renderer SHALL receive the old data and dirty SHALL remain set, so the new write wins and is published next commit.
REQ-029 The rd_we, rd_addr and rd_din outputs SHALL be registered, giving a latency of 1 cycle from the COPY decision to the renderer write.
REQ-030 busy SHALL be 1 in WAIT_VB, COPY and DONE, and whenever pend = 1.
REQ-031 rd_we SHALL be 0 outside COPY.
REQ-032 The rd_we, rd_addr and rd_din outputs SHALL never change except on a registered COPY cycle.

Reset
REQ-033 rstn low SHALL asynchronously set state = IDLE, idx = 0, pend = 0 and shadow = all 0.
REQ-034 rstn low SHALL asynchronously set dirty = 32'hFFFF_FFFF, so the first commit clears the renderer table.
REQ-035 rstn low SHALL set rd_we = 0, rd_addr = 0, rd_din = 0, busy = 0, commit_done = 0 and commit_count = 0.
REQ-036 Reset asserted mid-COPY SHALL abort the copy immediately; no further rd_we is issued.

Verification
REQ-037 Post-reset commit with vaddr = 650 SHALL produce 32 rd_we pulses, addr 0..31 with data 0, then commit_done and commit_count = 1.
REQ-038 A write of shadow[5] = 26'h1C0_2064, a commit_req at vaddr = 100, and vaddr ramped to 600 SHALL produce no rd_we before vblank and exactly one rd_we, addr 5, data 26'h1C0_2064.
REQ-039 A commit with dirty {3, 20} where vblank drops after idx 10 SHALL write addr 3, pause, then write addr 20 in the next vblank, with one commit_done.
REQ-040 Three commit_req pulses during COPY SHALL produce exactly one follow-up commit and commit_count increments by 2 in total.
REQ-041 cpu_we to idx 7 in the same cycle COPY processes idx 7 SHALL publish the old value, and the next commit SHALL publish the new value.
REQ-042 rstn pulsed low at idx 12 of COPY SHALL stop rd_we immediately, set busy = 0, and cause the next commit to write all 32 entries.

Source files
------------

// File: rtl/sprite_commit_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sprite_commit_scheduler                                      |
// | Description : Double-buffered sprite table; publishes dirty shadow entries |
// |               to the renderer table only during vertical blanking.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sprite_commit_scheduler #(
    parameter int VISIBLE_LINES = 600,
    parameter int ENTRIES       = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_addr,
    input  logic [25:0] cpu_din,
    input  logic        commit_req,
    input  logic [10:0] vga_vaddr,
    output logic        rd_we,
    output logic [31:0] rd_addr,
    output logic [31:0] rd_din,
    output logic        busy,
    output logic        commit_done,
    output logic [7:0]  commit_count
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_WAIT_VB  = 2'd1;
    localparam logic [1:0]  c_COPY     = 2'd2;
    localparam logic [1:0]  c_DONE     = 2'd3;
    localparam logic [10:0] c_VB_LINE  = 11'(VISIBLE_LINES);
    localparam logic [4:0]  c_LAST_IDX = 5'(ENTRIES - 1);

    logic [1:0]         r_state;
    logic [4:0]         r_idx;
    logic               r_pend;
    logic [25:0]        r_shadow [0:ENTRIES-1];
    logic [ENTRIES-1:0] r_dirty;
    logic               r_rd_we;
    logic [4:0]         r_rd_addr;
    logic [25:0]        r_rd_din;
    logic               r_commit_done;
    logic [7:0]         r_commit_count;
    logic               w_vblank;
    logic               w_copy_hit;

    assign w_vblank   = (vga_vaddr >= c_VB_LINE);
    assign w_copy_hit = (r_state == c_COPY) && r_dirty[r_idx];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (cpu_we) begin
            r_shadow[cpu_addr] <= cpu_din;
        end
    end

    // A CPU write landing on the entry being copied keeps it dirty: the set wins over the clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dirty <= '1;
        end else begin
            if (w_copy_hit) begin
                r_dirty[r_idx] <= 1'b0;
            end
            if (cpu_we) begin
                r_dirty[cpu_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= c_IDLE;
            r_idx          <= '0;
            r_pend         <= 1'b0;
            r_rd_we        <= 1'b0;
            r_rd_addr      <= '0;
            r_rd_din       <= '0;
            r_commit_done  <= 1'b0;
            r_commit_count <= '0;
        end else begin
            r_rd_we       <= 1'b0;
            r_commit_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (commit_req) begin
                        r_state <= c_WAIT_VB;
                        r_idx   <= '0;
                    end
                end
                c_WAIT_VB: begin
                    if (commit_req) begin
                        r_pend <= 1'b1;
                    end
                    if (w_vblank) begin
                        r_state <= c_COPY;
                    end
                end
                c_COPY: begin
                    if (commit_req) begin
                        r_pend <= 1'b1;
                    end
                    if (r_dirty[r_idx]) begin
                        r_rd_we   <= 1'b1;
                        r_rd_addr <= r_idx;
                        r_rd_din  <= r_shadow[r_idx];
                    end
                    // The current index always completes; leaving vblank only parks the scan.
                    if (r_idx == c_LAST_IDX) begin
                        r_state        <= c_DONE;
                        r_idx          <= '0;
                        r_commit_done  <= 1'b1;
                        r_commit_count <= r_commit_count + 8'd1;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                        if (!w_vblank) begin
                            r_state <= c_WAIT_VB;
                        end
                    end
                end
                c_DONE: begin
                    r_idx <= '0;
                    if (r_pend || commit_req) begin
                        r_state <= c_WAIT_VB;
                        r_pend  <= 1'b0;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rd_we        = r_rd_we;
    assign rd_addr      = {27'd0, r_rd_addr};
    assign rd_din       = {6'd0, r_rd_din};
    assign busy         = (r_state != c_IDLE) || r_pend;
    assign commit_done  = r_commit_done;
    assign commit_count = r_commit_count;

endmodule
`default_nettype wire

// File: tb/tb_sprite_commit_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sprite_commit_scheduler                                   |
// | Description : Directed bench with a commit-level scoreboard model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sprite_commit_scheduler;

    logic        clk;
    logic        rstn;
    logic        cpu_we;
    logic [4:0]  cpu_addr;
    logic [25:0] cpu_din;
    logic        commit_req;
    logic [10:0] vga_vaddr;
    logic        rd_we;
    logic [31:0] rd_addr;
    logic [31:0] rd_din;
    logic        busy;
    logic        commit_done;
    logic [7:0]  commit_count;

    sprite_commit_scheduler #(
        .VISIBLE_LINES(600),
        .ENTRIES      (32)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .commit_req  (commit_req),
        .vga_vaddr   (vga_vaddr),
        .rd_we       (rd_we),
        .rd_addr     (rd_addr),
        .rd_din      (rd_din),
        .busy        (busy),
        .commit_done (commit_done),
        .commit_count(commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: shadow contents and dirty set as the CPU sees them, plus the
    // writes each planned commit must publish, in ascending index order.
    logic [25:0] m_shadow [32];
    bit          m_dirty  [32];
    logic [7:0]  m_count;
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          planned_q [$];
    int          commit_seen;
    int          total_writes = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_shadow[i] = '0;
            m_dirty[i]  = 1'b1;
        end
        m_count = 8'd0;
        exp_addr.delete();
        exp_data.delete();
        planned_q.delete();
    endfunction

    function automatic void plan_commit();
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_dirty[i]) begin
                exp_addr.push_back(32'(i));
                exp_data.push_back({6'd0, m_shadow[i]});
                m_dirty[i] = 1'b0;
                n++;
            end
        end
        planned_q.push_back(n);
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            commit_seen = 0;
        end else begin
            if (rd_we) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_rd_we_addr", rd_addr, 32'hFFFF_FFFF);
                end else begin
                    check("rd_addr", rd_addr, exp_addr.pop_front());
                    check("rd_din", rd_din, exp_data.pop_front());
                end
                commit_seen++;
                total_writes++;
                last_addr = rd_addr;
                last_data = rd_din;
            end
            if (commit_done) begin
                if (planned_q.size() == 0) begin
                    check("unexpected_commit_done", 32'd1, 32'd0);
                end else begin
                    check("writes_per_commit", 32'(commit_seen), 32'(planned_q.pop_front()));
                end
                commit_seen = 0;
                m_count     = m_count + 8'd1;
                check("commit_count", {24'd0, commit_count}, {24'd0, m_count});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int a, input logic [25:0] d);
        cpu_we   = 1'b1;
        cpu_addr = a[4:0];
        cpu_din  = d;
        tick();
        cpu_we   = 1'b0;
        m_shadow[a] = d;
        m_dirty[a]  = 1'b1;
    endtask

    task automatic commit_pulse();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, {31'd0, busy}, 32'd0);
        #1;
    endtask

    int mark;

    initial begin
        rstn       = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_din    = '0;
        commit_req = 1'b0;
        vga_vaddr  = 11'd650;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("reset_rd_we", {31'd0, rd_we}, 32'd0);
        check("reset_rd_addr", rd_addr, 32'd0);
        check("reset_rd_din", rd_din, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_commit_done", {31'd0, commit_done}, 32'd0);
        check("reset_commit_count", {24'd0, commit_count}, 32'd0);

        // Post-reset commit clears the whole renderer table.
        mark = total_writes;
        plan_commit();
        commit_pulse();
        wait_idle(100, "t037_timeout");
        check("t037_writes", 32'(total_writes - mark), 32'd32);
        check("t037_last_addr", last_addr, 32'd31);
        check("t037_count", {24'd0, commit_count}, 32'd1);

        // Commit requested mid-frame waits for vblank; 599 is still visible.
        cpu_write(5, 26'h1C0_2064);
        vga_vaddr = 11'd100;
        mark = total_writes;
        plan_commit();
        commit_pulse();
        check("t038_busy", {31'd0, busy}, 32'd1);
        for (int v = 100; v <= 600; v += 20) begin
            vga_vaddr = (v == 600) ? 11'd599 : 11'(v);
            tick();
            check("t038_no_early_write", {31'd0, rd_we}, 32'd0);
        end
        vga_vaddr = 11'd600;
        wait_idle(100, "t038_timeout");
        check("t038_writes", 32'(total_writes - mark), 32'd1);
        check("t038_addr", last_addr, 32'd5);
        check("t038_data", last_data, 32'h01C0_2064);

        // vblank drops after idx 10: entry 3 goes out, entry 20 waits for next vblank.
        cpu_write(3, 26'h0AA_0003);
        cpu_write(20, 26'h155_0014);
        vga_vaddr = 11'd650;
        mark = total_writes;
        plan_commit();
        commit_pulse();
        repeat (11) tick();
        vga_vaddr = 11'd100;
        for (int k = 0; k < 15; k++) begin
            tick();
            check("t039_paused", {31'd0, rd_we}, 32'd0);
        end
        check("t039_mid_writes", 32'(total_writes - mark), 32'd1);
        check("t039_mid_busy", {31'd0, busy}, 32'd1);
        vga_vaddr = 11'd650;
        wait_idle(100, "t039_timeout");
        check("t039_writes", 32'(total_writes - mark), 32'd2);
        check("t039_last_addr", last_addr, 32'd20);
        check("t039_count", {24'd0, commit_count}, 32'd3);

        // CPU write to idx 7 in the very cycle the scan processes idx 7.
        cpu_write(7, 26'h000_1111);
        mark = total_writes;
        plan_commit();
        commit_pulse();
        repeat (8) tick();
        cpu_write(7, 26'h3FF_2222);
        wait_idle(100, "t041_timeout");
        check("t041_writes", 32'(total_writes - mark), 32'd1);
        check("t041_old_data", last_data, 32'h0000_1111);
        plan_commit();
        commit_pulse();
        wait_idle(100, "t041b_timeout");
        check("t041_new_addr", last_addr, 32'd7);
        check("t041_new_data", last_data, 32'h03FF_2222);
        check("t041_count", {24'd0, commit_count}, 32'd5);

        // Three requests during COPY collapse into one follow-up commit.
        cpu_write(30, 26'h123_4567);
        mark = total_writes;
        plan_commit();
        commit_pulse();
        repeat (5) tick();
        commit_pulse();
        tick();
        commit_pulse();
        cpu_write(1, 26'h2BC_0001);
        commit_pulse();
        plan_commit();
        wait_idle(200, "t040_timeout");
        check("t040_writes", 32'(total_writes - mark), 32'd2);
        check("t040_last_addr", last_addr, 32'd1);
        check("t040_count", {24'd0, commit_count}, 32'd7);
        repeat (40) tick();
        check("t040_no_extra", {24'd0, commit_count}, 32'd7);

        // Reset while the scan sits on idx 12 aborts the copy.
        cpu_write(2, 26'h001_0002);
        cpu_write(12, 26'h001_000C);
        cpu_write(20, 26'h001_0014);
        plan_commit();
        commit_pulse();
        repeat (13) tick();
        @(negedge clk);
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        check("t042_rd_we", {31'd0, rd_we}, 32'd0);
        check("t042_busy", {31'd0, busy}, 32'd0);
        check("t042_count", {24'd0, commit_count}, 32'd0);
        repeat (2) tick();
        check("t042_rd_we_held", {31'd0, rd_we}, 32'd0);
        rstn = 1'b1;
        tick();
        mark = total_writes;
        plan_commit();
        commit_pulse();
        wait_idle(100, "t042_timeout");
        check("t042_writes", 32'(total_writes - mark), 32'd32);
        check("t042_final_count", {24'd0, commit_count}, 32'd1);

        check("leftover_expected", 32'(exp_addr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
